// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode encodings and FSM state encodings.
package timer_dev_pkg;

  localparam int unsigned DATA_W = 32;

  // Register offsets, decoded from Addr[3:2]
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;
  localparam int unsigned CTRL_W        = 4;

  // Mode encodings; 2'b10 and 2'b11 fall back to one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_e;

  // Field order matches the CTRL bit positions above (im is bit 3)
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
    return {{(DATA_W-CTRL_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Data-side load/store bus between the system bridge (master) and the timer
// (slave), plus the timer's interrupt request line.
interface timer_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  modport master (output Addr, output WE, output WD, input RD, input IRQ);
  modport slave  (input Addr, input WE, input WD, output RD, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Countdown timer responder: CTRL/PRESET/COUNT registers, a four-state
// IDLE/LOAD/CNT/INT sequencer, and a maskable interrupt request.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  state_e              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                irq_pend_q, irq_pend_d;

  logic [1:0]          reg_sel;
  logic                wr_ctrl, wr_preset;
  logic [DATA_W-1:0]   rd;
  logic                unused_addr;

  assign reg_sel     = bus.Addr[3:2];
  assign wr_ctrl     = bus.WE && (reg_sel == ADDR_CTRL);
  assign wr_preset   = bus.WE && (reg_sel == ADDR_PRESET);
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > {{(DATA_W-1){1'b0}}, 1'b1}) begin
          count_d = count_q - 1'b1;
        end else begin
          count_d    = '0;
          irq_pend_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          irq_pend_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU stores are applied last so they override any same-edge FSM update
    if (wr_preset) preset_d = bus.WD;
    if (wr_ctrl) begin
      ctrl_d     = ctrl_t'(bus.WD[CTRL_W-1:0]);
      irq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    rd = '0;
    unique case (reg_sel)
      ADDR_CTRL:   rd = ctrl_to_word(ctrl_q);
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = '0;
    endcase
  end

  assign bus.RD  = rd;
  assign bus.IRQ = irq_pend_q & ctrl_q.im;

endmodule
